// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Purpose:
//   Memory-side responder for the MEM-stage data-memory request/ready
//   handshake. It accepts one read or write per transaction and models a
//   fixed multi-cycle access latency. It pulses rdy for one cycle when the
//   access completes. The pipeline stalls while rdy is low.
//
// Parameters:
//   ADDR_W     request address width (byte address, bit 0 ignored)
//   DATA_W     data word width
//   DEPTH_LOG2 log2 of the number of words; index = addr[DEPTH_LOG2:1]
//   LATENCY    cycles from request acceptance to rdy (1..15)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   addr       request address, held by the requester until rdy
//   re / we    read / write request (both high is treated as a write)
//   wdata      write data, held with we
//   rd_data    last completed read word; held until the next read completes
//   rdy        one-cycle completion pulse
//   busy       transaction in flight (BUSY or DONE state)
//   proto_err  sticky flag: re and we were seen together at acceptance
//
// Build option:
//   DMEM_ACCESS_CNT_EN  when defined, adds the rd_cnt/wr_cnt outputs.
//                       These are saturating 16-bit counts of completed
//                       reads and writes.
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 14,
  parameter int LATENCY    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              re,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rd_data,
  output logic              rdy,
  output logic              busy,
`ifdef DMEM_ACCESS_CNT_EN
  output logic [15:0]       rd_cnt,
  output logic [15:0]       wr_cnt,
`endif
  output logic              proto_err
);

  localparam int         DEPTH  = 2 ** DEPTH_LOG2;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State and holding registers
  // ---------------------------------------------------------------------------
  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [DATA_W-1:0]       wdata_q;
  logic                    is_wr_q;
  logic                    proto_err_q;
  logic                    rd_valid_q;
  logic [DATA_W-1:0]       rd_word_q;

  logic                    accept;
  logic                    commit;
  logic [DEPTH_LOG2-1:0]   commit_idx;
  logic [DATA_W-1:0]       commit_wdata;
  logic                    commit_wr;
  logic                    commit_rd;

  // Address bits outside the word index play no part in the access.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[ADDR_W-1:DEPTH_LOG2+1], addr[0]};

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (re || we) begin
          accept = 1'b1;
          cnt_d  = LAT_M1;
          if (LATENCY == 1) begin
            // A single-cycle access completes on the acceptance edge itself.
            state_d = S_DONE;
            commit  = 1'b1;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        // Inputs are ignored here; only the latched request is used.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_DONE;
          commit  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // The access happens on the edge that enters DONE. With LATENCY=1 that is
  // the acceptance edge, so the live inputs stand in for the holding registers.
  always_comb begin
    if (accept) begin
      commit_idx   = addr[DEPTH_LOG2:1];
      commit_wdata = wdata;
      commit_wr    = we;
    end else begin
      commit_idx   = idx_q;
      commit_wdata = wdata_q;
      commit_wr    = is_wr_q;
    end
  end

  // Reset aborts immediately, so nothing may commit while rst is high.
  assign commit_rd = commit && !commit_wr && !rst;

  // ---------------------------------------------------------------------------
  // FSM registers, holding registers, sticky error
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= '0;
      wdata_q     <= '0;
      is_wr_q     <= 1'b0;
      proto_err_q <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q   <= addr[DEPTH_LOG2:1];
        wdata_q <= wdata;
        is_wr_q <= we;
        if (re && we) begin
          proto_err_q <= 1'b1;
        end
      end
      if (commit_rd) begin
        rd_valid_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array: single port with a registered read and no reset, so it
  // maps onto block RAM. rd_data reads as zero until the first read after
  // reset completes, because rd_valid_q gates the RAM output register.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (commit && commit_wr && !rst) begin
      mem_q[commit_idx] <= commit_wdata;
    end
    if (commit_rd) begin
      rd_word_q <= mem_q[commit_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Optional access counters (count on the DONE cycle, saturating)
  // ---------------------------------------------------------------------------
`ifdef DMEM_ACCESS_CNT_EN
  logic [15:0] rd_cnt_q;
  logic [15:0] wr_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else if (state_q == S_DONE) begin
      if (is_wr_q) begin
        if (wr_cnt_q != 16'hFFFF) begin
          wr_cnt_q <= wr_cnt_q + 16'd1;
        end
      end else begin
        if (rd_cnt_q != 16'hFFFF) begin
          rd_cnt_q <= rd_cnt_q + 16'd1;
        end
      end
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`endif

  // ---------------------------------------------------------------------------
  // Outputs (all decoded straight from registers)
  // ---------------------------------------------------------------------------
  assign rdy       = (state_q == S_DONE);
  assign busy      = (state_q == S_BUSY) || (state_q == S_DONE);
  assign rd_data   = rd_valid_q ? rd_word_q : '0;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr = '0;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [15:0] wdata = '0;
  logic [15:0] rd_data;
  logic        rdy;
  logic        busy;
  logic        proto_err;
`ifdef DMEM_ACCESS_CNT_EN
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;
`endif

  dmem_responder #(
    .ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(14), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .re(re), .we(we), .wdata(wdata),
    .rd_data(rd_data), .rdy(rdy), .busy(busy),
`ifdef DMEM_ACCESS_CNT_EN
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt),
`endif
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Reference model: word-addressed memory plus the visible registers.
  logic [15:0] ref_mem [int];
  logic [15:0] ref_rd   = '0;
  logic        ref_perr = 1'b0;
  int          ref_rcnt = 0;
  int          ref_wcnt = 0;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int widx(input logic [15:0] a);
    return int'((a >> 1) & 16'h3FFF);
  endfunction

  // One complete transaction, driven at negedges and observed at negedges.
  // chg: change addr/wdata while the request is in flight.
  task automatic txn(input string tag, input logic r, input logic w,
                     input logic [15:0] a, input logic [15:0] d,
                     input bit chg, input logic [15:0] ca, input logic [15:0] cd);
    int          cyc;
    bit          is_wr;
    logic [15:0] exp_rd;
    @(negedge clk);
    chk({tag, ".idle_busy"}, {31'd0, busy}, 32'd0);
    addr = a; wdata = d; re = r; we = w;
    is_wr = w;
    if (r && w) ref_perr = 1'b1;
    if (is_wr) begin
      ref_mem[widx(a)] = d;
      ref_wcnt++;
    end else begin
      ref_rd = ref_mem.exists(widx(a)) ? ref_mem[widx(a)] : 16'hxxxx;
      ref_rcnt++;
    end
    exp_rd = ref_rd;
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (chg && cyc == 1) begin
        addr = ca; wdata = cd;
      end
      if (rdy) break;
      chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
    end
    chk({tag, ".lat"}, cyc, LAT);
    chk({tag, ".busy_done"}, {31'd0, busy}, 32'd1);
    chk({tag, ".rd_data"}, {16'd0, rd_data}, {16'd0, exp_rd});
    chk({tag, ".perr"}, {31'd0, proto_err}, {31'd0, ref_perr});
    re = 1'b0; we = 1'b0;
    $display("txn %s re=%0b we=%0b addr=%h wdata=%h -> rd_data=%h lat=%0d",
             tag, r, w, a, d, rd_data, cyc);
`ifdef DMEM_ACCESS_CNT_EN
    @(negedge clk);
    chk({tag, ".rd_cnt"}, {16'd0, rd_cnt}, ref_rcnt);
    chk({tag, ".wr_cnt"}, {16'd0, wr_cnt}, ref_wcnt);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pool [8];
    int          k;
    logic [15:0] a;

    // Initial async reset, checked before any clock edge acts on it.
    #2 rst = 1'b1;
    #1;
    chk("rst0.rdy", {31'd0, rdy}, 32'd0);
    chk("rst0.busy", {31'd0, busy}, 32'd0);
    chk("rst0.rd_data", {16'd0, rd_data}, 32'd0);
    chk("rst0.perr", {31'd0, proto_err}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Write then read, bit-0 and high-bit aliasing.
    txn("wr10", 0, 1, 16'h0010, 16'hBEEF, 0, 0, 0);
    txn("rd10", 1, 0, 16'h0010, 16'h0000, 0, 0, 0);
    txn("rd11", 1, 0, 16'h0011, 16'h0000, 0, 0, 0);
    txn("rd8010", 1, 0, 16'h8010, 16'h0000, 0, 0, 0);

    // Inputs changed during BUSY must be ignored.
    txn("wr22", 0, 1, 16'h0022, 16'h7777, 0, 0, 0);
    txn("wr20chg", 0, 1, 16'h0020, 16'h1234, 1, 16'h0022, 16'hFFFF);
    txn("rd20", 1, 0, 16'h0020, 16'h0000, 0, 0, 0);
    txn("rd22", 1, 0, 16'h0022, 16'h0000, 0, 0, 0);

    // re&we together: write, sticky proto_err.
    txn("rwe40", 1, 1, 16'h0040, 16'h0F0F, 0, 0, 0);
    txn("rd40", 1, 0, 16'h0040, 16'h0000, 0, 0, 0);

    // Reset in the middle of a write: aborted, no rdy, no commit.
    txn("wr30", 0, 1, 16'h0030, 16'h5555, 0, 0, 0);
    @(negedge clk);
    addr = 16'h0030; wdata = 16'hAAAA; we = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    ref_rd = '0; ref_perr = 1'b0; ref_rcnt = 0; ref_wcnt = 0;
    chk("rstmid.rdy", {31'd0, rdy}, 32'd0);
    chk("rstmid.busy", {31'd0, busy}, 32'd0);
    chk("rstmid.rd_data", {16'd0, rd_data}, 32'd0);
    chk("rstmid.perr", {31'd0, proto_err}, 32'd0);
    we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rstmid.no_rdy", {31'd0, rdy}, 32'd0);
    end
    txn("rd30", 1, 0, 16'h0030, 16'h0000, 0, 0, 0);

    // Randomized traffic over a small address pool, including aliases.
    for (int i = 0; i < 8; i++) begin
      pool[i] = 16'($urandom_range(0, 16'h7FFF)) & 16'h7FFE;
      txn("rinit", 0, 1, pool[i], 16'($urandom), 0, 0, 0);
    end
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 7);
      a = pool[k] ^ {$urandom_range(0, 1) == 1, 14'd0, $urandom_range(0, 1) == 1};
      case ($urandom_range(0, 7))
        0:       txn("rand_rw", 1, 1, a, 16'($urandom), 0, 0, 0);
        1, 2, 3: txn("rand_wr", 0, 1, a, 16'($urandom), 0, 0, 0);
        default: txn("rand_rd", 1, 0, a, 16'($urandom), 0, 0, 0);
      endcase
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
